// File: rtl/cmp_sweep_checker.sv
// Self-test sweep engine for a WIDTH-bit magnitude comparator: drives every {A,B}, checks F1/F2/F3, reports errors.
// Optional CMP_STOP_ON_ERR_EN: halt at the first mismatch with the failing vector left on a_out/b_out.
module cmp_sweep_checker #(
    parameter int WIDTH      = 2,
    parameter int SETTLE_CYC = 4,
    parameter int ERR_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 f_gt,
    input  logic                 f_eq,
    input  logic                 f_lt,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [2*WIDTH-1:0]   first_err
);

    localparam int VW = 2 * WIDTH;
    localparam logic [VW-1:0]    LAST_IDX  = '1;
    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [VW-1:0]     idx;
    logic [7:0]        settle_cnt;
    logic [ERR_W-1:0]  err_q;
    logic [VW-1:0]     first_q;
    logic              pass_q;
    logic [WIDTH-1:0]  a_cur;
    logic [WIDTH-1:0]  b_cur;
    logic              mismatch;
    logic              stop_hit;

    // The vector index doubles as the operand register: A is the upper half.
    assign a_cur = idx[VW-1:WIDTH];
    assign b_cur = idx[WIDTH-1:0];

    // Expected flags are one-hot, so any non-one-hot response mismatches.
    assign mismatch = ({f_gt, f_eq, f_lt} != {a_cur > b_cur, a_cur == b_cur, a_cur < b_cur});

`ifdef CMP_STOP_ON_ERR_EN
    assign stop_hit = mismatch;
`else
    assign stop_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == 8'd0) state_nxt = CHECK;
            CHECK:   state_nxt = (idx == LAST_IDX || stop_hit) ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            settle_cnt <= '0;
            err_q      <= '0;
            first_q    <= '0;
            pass_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        settle_cnt <= SETTLE_LD;
                        err_q      <= '0;
                        first_q    <= '0;
                        pass_q     <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
                        if (err_q == '0) first_q <= idx;
                    end
                    // pass is latched on entry to DONE so it is visible alongside the done pulse.
                    if (state_nxt == DONE) begin
                        pass_q <= (err_q == '0) && !mismatch;
                    end else begin
                        idx        <= idx + 1'b1;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state == SETTLE) || (state == CHECK);
        done      = (state == DONE);
        pass      = pass_q;
        err_cnt   = err_q;
        first_err = first_q;
        a_out     = a_cur;
        b_out     = b_cur;
    end

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Directed bench for cmp_sweep_checker with a behavioural comparator that can carry injected faults.
module tb_cmp_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] a_out, b_out;
    logic       f_gt, f_eq, f_lt;
    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic [3:0] first_err;

    int total = 0;
    int bad   = 0;
    int mode  = 0;  // 0 good, 1 eq stuck 0, 2 gt/lt swapped, 3 lt stuck 1

    cmp_sweep_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_out), .b_out(b_out),
        .f_gt(f_gt), .f_eq(f_eq), .f_lt(f_lt),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err(first_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        f_gt = a_out > b_out;
        f_eq = a_out == b_out;
        f_lt = a_out < b_out;
        case (mode)
            1: f_eq = 1'b0;
            2: begin f_gt = a_out < b_out; f_lt = a_out > b_out; end
            3: f_lt = 1'b1;
            default: ;
        endcase
    end

    // Pulses start, optionally re-pulses it at cycles p1/p2, and returns the cycle
    // number (the sampling edge opens cycle 1) on which done is seen, or -1 on timeout.
    task automatic run_sweep(input int p1, input int p2, output int lat);
        int cyc;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        lat = -1;
        while (cyc < 300 && lat < 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (done) lat = cyc + 1;
            else if (cyc == p1 || cyc == p2) start = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({a_out, b_out, busy, done, pass, err_cnt, first_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: a=%0d b=%0d busy=%b done=%b pass=%b err=%0d first=%0d, want all 0",
                     a_out, b_out, busy, done, pass, err_cnt, first_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_sweep;
        int cyc, lat;
        logic [3:0] vexp;
        mode = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        total++;
        if (a_out !== 2'd0 || b_out !== 2'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL clean_first_vec: a=%0d b=%0d busy=%b, want 0 0 1", a_out, b_out, busy);
        end
        cyc = 0;
        lat = -1;
        while (cyc < 300 && lat < 0) begin
            @(posedge clk); #1;
            cyc++;
            if (done) lat = cyc + 1;
            else if (cyc % 5 == 2 && cyc < 80) begin
                vexp = 4'(cyc / 5);
                total++;
                if ({a_out, b_out} !== vexp || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL clean_vec_%0d: ab=%0d busy=%b, want ab=%0d busy=1", cyc, {a_out, b_out}, busy, vexp);
                end
            end
        end
        total++;
        if (lat != 81 || pass !== 1'b1 || err_cnt !== 8'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clean_done: lat=%0d pass=%b err=%0d busy=%b, want 81 1 0 0", lat, pass, err_cnt, busy);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || pass !== 1'b1 || {a_out, b_out} !== 4'hF) begin
            bad++;
            $display("FAIL clean_hold: done=%b pass=%b ab=%0d, want 0 1 15", done, pass, {a_out, b_out});
        end
    endtask

    task automatic test_eq_stuck;
        int lat;
        mode = 1;
        run_sweep(-1, -1, lat);
        total++;
        if (lat != 81 || err_cnt !== 8'd4 || first_err !== 4'b0000 || pass !== 1'b0) begin
            bad++;
            $display("FAIL eq_stuck: lat=%0d err=%0d first=%0d pass=%b, want 81 4 0 0", lat, err_cnt, first_err, pass);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (err_cnt !== 8'd4 || first_err !== 4'b0000 || pass !== 1'b0) begin
            bad++;
            $display("FAIL eq_stuck_hold: err=%0d first=%0d pass=%b, want 4 0 0", err_cnt, first_err, pass);
        end
    endtask

    task automatic test_swap;
        int lat;
        mode = 2;
        run_sweep(-1, -1, lat);
        total++;
        if (lat != 81 || err_cnt !== 8'd12 || first_err !== 4'b0001 || pass !== 1'b0) begin
            bad++;
            $display("FAIL swap: lat=%0d err=%0d first=%0d pass=%b, want 81 12 1 0", lat, err_cnt, first_err, pass);
        end
    endtask

    task automatic test_lt_stuck;
        int lat;
        mode = 3;
        run_sweep(-1, -1, lat);
`ifdef CMP_STOP_ON_ERR_EN
        total++;
        if (lat != 6 || err_cnt !== 8'd1 || first_err !== 4'd0 || a_out !== 2'd0 || b_out !== 2'd0 || pass !== 1'b0) begin
            bad++;
            $display("FAIL stop_on_err: lat=%0d err=%0d first=%0d a=%0d b=%0d pass=%b, want 6 1 0 0 0 0",
                     lat, err_cnt, first_err, a_out, b_out, pass);
        end
`else
        // lt stuck high breaks every vector with A>=B: 10 of 16.
        total++;
        if (lat != 81 || err_cnt !== 8'd10 || first_err !== 4'd0 || pass !== 1'b0) begin
            bad++;
            $display("FAIL lt_stuck: lat=%0d err=%0d first=%0d pass=%b, want 81 10 0 0", lat, err_cnt, first_err, pass);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int seen_done, lat;
        mode = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || err_cnt !== 8'd2) begin
            bad++;
            $display("FAIL mid_pre_reset: busy=%b err=%0d, want 1 2", busy, err_cnt);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if ({a_out, b_out, busy, done, pass, err_cnt, first_err} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: a=%0d b=%0d busy=%b done=%b pass=%b err=%0d first=%0d, want all 0",
                     a_out, b_out, busy, done, pass, err_cnt, first_err);
        end
        seen_done = 0;
        for (int i = 0; i < 90; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        total++;
        if (seen_done != 0) begin
            bad++;
            $display("FAIL mid_reset_quiet: active cycles=%0d, want 0", seen_done);
        end
        mode = 0;
        run_sweep(-1, -1, lat);
        total++;
        if (lat != 81 || pass !== 1'b1 || err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL mid_reset_resweep: lat=%0d pass=%b err=%0d, want 81 1 0", lat, pass, err_cnt);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        mode = 1;
        run_sweep(10, 40, lat);
        total++;
        if (lat != 81 || err_cnt !== 8'd4) begin
            bad++;
            $display("FAIL start_ignored: lat=%0d err=%0d, want 81 4", lat, err_cnt);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, lat;
        mode = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (cyc < 300 && !done) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc + 1 != 81) begin
            bad++;
            $display("FAIL b2b_first_lat: lat=%0d, want 81", cyc + 1);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b, want 0 0", busy, done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || {a_out, b_out} !== 4'd0 || pass !== 1'b0) begin
            bad++;
            $display("FAIL b2b_restart: busy=%b ab=%0d pass=%b, want 1 0 0", busy, {a_out, b_out}, pass);
        end
        lat = -1;
        cyc = 0;
        while (cyc < 300 && lat < 0) begin
            @(posedge clk); #1;
            cyc++;
            if (done) lat = cyc + 1;
        end
        total++;
        if (lat != 81 || pass !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: lat=%0d pass=%b, want 81 1", lat, pass);
        end
    endtask

    initial begin
        test_reset;
        test_clean_sweep;
        test_eq_stuck;
        test_swap;
        test_lt_stuck;
        test_reset_mid;
        test_start_ignored;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_sweep_checker.md
Name: cmp_sweep_checker

Overview:
- Synthesizable self-test engine for the 2-bit magnitude comparator.
- Drives every operand pair (A, B) into the comparator and samples its F1/F2/F3 flags.
- Checks each sample against an internally computed expected result.
- Reports the error count, the first failing vector and a pass/done status.
- Sits beside the comparator as its stimulus/response counterpart for on-board checking without a simulator.

Parameters:
- WIDTH, 2: operand width in bits; the sweep covers 2^(2*WIDTH) vectors.
- SETTLE_CYC, 4: clock cycles operands are held before flags are sampled; legal range 1..255.
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begins a sweep when sampled high in IDLE; ignored in all other states.
- a_out  out  WIDTH  operand A to the comparator; bit WIDTH-1 maps to A1 (MSB).
- b_out  out  WIDTH  operand B to the comparator; bit WIDTH-1 maps to B1 (MSB).
- f_gt  in  1  comparator F1; expected to be 1 when A>B.
- f_eq  in  1  comparator F2; expected to be 1 when A==B.
- f_lt  in  1  comparator F3; expected to be 1 when A<B.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep ends.
- pass  out  1  high when the last completed sweep had zero errors; held until the next start.
- err_cnt  out  ERR_W  mismatch count; saturates at all-ones.
- first_err  out  2*WIDTH  index {A,B} of the first mismatching vector; valid when err_cnt is nonzero.

Behaviour:
- Reset (rst_n=0 at a clk edge), all outputs 0:
  - state=IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, err_cnt=0, first_err=0.
  - Internal vector index idx=0 and settle counter=0.
  - Reset takes effect mid-sweep with no done pulse.
- States:
  - IDLE:
    - When start=1: go to SETTLE next cycle.
    - On that transition: idx=0, a_out=0, b_out=0, busy=1, err_cnt=0, first_err=0, pass=0, settle counter loaded with SETTLE_CYC-1.
  - SETTLE:
    - Counter decrements each cycle.
    - When the counter is 0, go to CHECK next cycle.
    - Operands are therefore stable for exactly SETTLE_CYC cycles before CHECK.
  - CHECK (one cycle):
    - Expected flags: gt=(a_out>b_out), eq=(a_out==b_out), lt=(a_out<b_out), unsigned compare.
    - Mismatch = any of the three flags differs from expected.
    - A non-one-hot flag set (000, 011, 111 etc.) is always a mismatch.
    - On mismatch: err_cnt increments, saturating at 2^ERR_W-1; first_err={a_out,b_out} only if err_cnt was 0.
    - If idx = 2^(2*WIDTH)-1: go to DONE.
    - Otherwise: idx increments, {a_out,b_out} take the new idx (A is the upper WIDTH bits, B the lower), the counter reloads and the state returns to SETTLE.
  - DONE (one cycle):
    - done=1, busy=0, pass=(err_cnt==0), then go to IDLE.
    - a_out/b_out keep the last vector.
    - err_cnt, first_err and pass hold until the next start.
- Timing:
  - Sweep latency from the start-sample edge to the done pulse: 2^(2*WIDTH)*(SETTLE_CYC+1)+1 cycles.
  - With the defaults that is 81; done is high on the 81st cycle after the edge that sampled start.
- Boundaries:
  - start held high continuously: a new sweep begins in the cycle after DONE returns to IDLE.
  - start asserted during SETTLE, CHECK or DONE is ignored.
  - SETTLE_CYC=1 means the counter is loaded with 0: exactly one SETTLE cycle per vector.

Optional Feature:
- Macro: CMP_STOP_ON_ERR_EN.
- Defined: the first mismatch in CHECK goes directly to DONE; err_cnt=1, first_err=failing vector, pass=0, and a_out/b_out hold the failing vector for probing.
- Undefined: the full sweep always completes and all mismatches are counted.

Test Plan:
- Correct comparator model, defaults, start pulsed one cycle:
  - a_out/b_out step through 0/0, 0/1 … 3/3, each held 5 cycles.
  - done pulses 81 cycles after start; pass=1, err_cnt=0.
- f_eq stuck at 0:
  - The 4 equal vectors fail.
  - err_cnt=4, first_err=4'b0000, pass=0.
- f_gt and f_lt swapped:
  - 12 mismatches; err_cnt=12, first_err=4'b0001 (A=0, B=1).
- rst_n driven low for one cycle at cycle 30 of a sweep:
  - All outputs are 0 next cycle, no done pulse.
  - A later start gives a clean 81-cycle sweep.
- start pulsed again at cycles 10 and 40 of a running sweep:
  - No effect; done still pulses at cycle 81.
- With CMP_STOP_ON_ERR_EN defined and f_lt stuck at 1:
  - Stop at vector A=0, B=0; done pulses 6 cycles after start.
  - err_cnt=1, first_err=0, a_out=b_out=0.
